// File: rtl/fv_core_mi_capture.sv
`default_nettype none
// ============================================================================
// Module : fv_core_mi_capture
// Brief  : In-order operand capture for up to NUM_SLOTS in-flight instructions,
//          emitting one registered check record per retirement.
// Rev    : 1.0
// ============================================================================
module fv_core_mi_capture #(
   parameter int NUM_SLOTS   = 4,
   parameter int REG_WIDTH   = 32,
   parameter int NUM_REGS    = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int TIMEOUT     = 63
) (
   input  logic                          clk,
   input  logic                          reset_,
   input  logic [NUM_REGS*REG_WIDTH-1:0] arf,
   input  logic                          start,
   input  logic                          launch_en,
   input  logic [INSTR_WIDTH-1:0]        instruction,
   input  logic                          instruction_valid,
   input  logic [ADDR_WIDTH-1:0]         pc,
   input  logic                          retire_valid,
   input  logic [REG_WIDTH-1:0]          retire_rd_value,
   output logic                          nop_required,
   output logic                          launched,
   output logic [$clog2(NUM_SLOTS):0]    slots_used,
   output logic                          chk_valid,
   output logic [$clog2(NUM_SLOTS)-1:0]  chk_seq,
   output logic [INSTR_WIDTH-1:0]        chk_instr,
   output logic [ADDR_WIDTH-1:0]         chk_pc,
   output logic [REG_WIDTH-1:0]          chk_rs1_value,
   output logic [REG_WIDTH-1:0]          chk_rs2_value,
   output logic [1:0]                    chk_rs_dep,
   output logic [REG_WIDTH-1:0]          chk_rd_value,
   output logic [2:0]                    state_o,
   output logic                          err_timeout,
   output logic                          err_spurious
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam int CW = SW + 1;
   localparam int AW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_DRAIN   = 3'd2,
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          launch_cnt_q, launch_cnt_d;
   logic [CW-1:0]          count_q, count_d;
   logic [SW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          age_q, age_d;
   logic                   err_timeout_q, err_timeout_d;
   logic                   err_spurious_q, err_spurious_d;

   logic [INSTR_WIDTH-1:0] ent_instr_q [NUM_SLOTS];
   logic [INSTR_WIDTH-1:0] ent_instr_d [NUM_SLOTS];
   logic [ADDR_WIDTH-1:0]  ent_pc_q    [NUM_SLOTS];
   logic [ADDR_WIDTH-1:0]  ent_pc_d    [NUM_SLOTS];
   logic [SW-1:0]          ent_seq_q   [NUM_SLOTS];
   logic [SW-1:0]          ent_seq_d   [NUM_SLOTS];
   logic [REG_WIDTH-1:0]   ent_rs1_q   [NUM_SLOTS];
   logic [REG_WIDTH-1:0]   ent_rs1_d   [NUM_SLOTS];
   logic [REG_WIDTH-1:0]   ent_rs2_q   [NUM_SLOTS];
   logic [REG_WIDTH-1:0]   ent_rs2_d   [NUM_SLOTS];
   logic [1:0]             ent_dep_q   [NUM_SLOTS];
   logic [1:0]             ent_dep_d   [NUM_SLOTS];

   logic                   chk_valid_q, chk_valid_d;
   logic [SW-1:0]          chk_seq_q, chk_seq_d;
   logic [INSTR_WIDTH-1:0] chk_instr_q, chk_instr_d;
   logic [ADDR_WIDTH-1:0]  chk_pc_q, chk_pc_d;
   logic [REG_WIDTH-1:0]   chk_rs1_q, chk_rs1_d;
   logic [REG_WIDTH-1:0]   chk_rs2_q, chk_rs2_d;
   logic [1:0]             chk_dep_q, chk_dep_d;
   logic [REG_WIDTH-1:0]   chk_rd_q, chk_rd_d;

   logic                   full, empty, active, pop, spurious, launch;
   logic [4:0]             rs1_idx, rs2_idx, ent_rd;
   logic [REG_WIDTH-1:0]   rs1_val, rs2_val;
   logic [1:0]             dep;
   logic [SW-1:0]          slot;

   assign full     = (count_q == CW'(NUM_SLOTS));
   assign empty    = (count_q == '0);
   assign active   = (state_q != S_IDLE) && (state_q != S_ERROR);
   assign pop      = retire_valid && !empty && active;
   assign spurious = retire_valid && (state_q != S_ERROR) && (empty || (state_q == S_IDLE));
   assign launch   = (state_q == S_CAPTURE) && launch_en && instruction_valid &&
                     (!full || retire_valid);

   always_comb begin
      rs1_idx = instruction[19:15];
      rs2_idx = instruction[24:20];
      rs1_val = '0;
      rs2_val = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (rs1_idx == 5'(r)) rs1_val = arf[r*REG_WIDTH +: REG_WIDTH];
         if (rs2_idx == 5'(r)) rs2_val = arf[r*REG_WIDTH +: REG_WIDTH];
      end
      // The head leaving this cycle has already produced its result, so it cannot hazard.
      dep    = 2'b00;
      slot   = '0;
      ent_rd = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot   = rd_ptr_q + SW'(i);
         ent_rd = ent_instr_q[slot][11:7];
         if ((CW'(i) < count_q) && !(pop && (i == 0)) && (ent_rd != 5'd0)) begin
            if (ent_rd == rs1_idx) dep[0] = 1'b1;
            if (ent_rd == rs2_idx) dep[1] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      launch_cnt_d   = launch_cnt_q;
      count_d        = count_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      age_d          = age_q;
      err_timeout_d  = err_timeout_q;
      err_spurious_d = err_spurious_q;
      ent_instr_d    = ent_instr_q;
      ent_pc_d       = ent_pc_q;
      ent_seq_d      = ent_seq_q;
      ent_rs1_d      = ent_rs1_q;
      ent_rs2_d      = ent_rs2_q;
      ent_dep_d      = ent_dep_q;
      chk_valid_d    = 1'b0;
      chk_seq_d      = chk_seq_q;
      chk_instr_d    = chk_instr_q;
      chk_pc_d       = chk_pc_q;
      chk_rs1_d      = chk_rs1_q;
      chk_rs2_d      = chk_rs2_q;
      chk_dep_d      = chk_dep_q;
      chk_rd_d       = chk_rd_q;

      if (pop) begin
         chk_valid_d = 1'b1;
         chk_seq_d   = ent_seq_q[rd_ptr_q];
         chk_instr_d = ent_instr_q[rd_ptr_q];
         chk_pc_d    = ent_pc_q[rd_ptr_q];
         chk_rs1_d   = ent_rs1_q[rd_ptr_q];
         chk_rs2_d   = ent_rs2_q[rd_ptr_q];
         chk_dep_d   = ent_dep_q[rd_ptr_q];
         chk_rd_d    = retire_rd_value;
         rd_ptr_d    = rd_ptr_q + SW'(1);
      end

      if (launch) begin
         ent_instr_d[wr_ptr_q] = instruction;
         ent_pc_d[wr_ptr_q]    = pc;
         ent_seq_d[wr_ptr_q]   = launch_cnt_q[SW-1:0];
         ent_rs1_d[wr_ptr_q]   = rs1_val;
         ent_rs2_d[wr_ptr_q]   = rs2_val;
         ent_dep_d[wr_ptr_q]   = dep;
         wr_ptr_d              = wr_ptr_q + SW'(1);
         launch_cnt_d          = launch_cnt_q + CW'(1);
      end

      case ({launch, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Age counts edges the current head has waited; the error fires on the edge it reaches TIMEOUT.
      if (state_q != S_ERROR) begin
         if (pop || (launch && empty)) begin
            age_d = '0;
         end else if (!empty) begin
            if (age_q != AW'(TIMEOUT)) age_d = age_q + AW'(1);
            if (age_q >= AW'(TIMEOUT - 1)) err_timeout_d = 1'b1;
         end
      end

      if (spurious) err_spurious_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (err_timeout_d || err_spurious_d)                   state_d = S_ERROR;
            else if (launch && (launch_cnt_q == CW'(NUM_SLOTS - 1))) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (err_timeout_d || err_spurious_d) state_d = S_ERROR;
            else if (count_d == '0)             state_d = S_DONE;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q        <= S_IDLE;
         launch_cnt_q   <= '0;
         count_q        <= '0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         age_q          <= '0;
         err_timeout_q  <= 1'b0;
         err_spurious_q <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            ent_instr_q[i] <= '0;
            ent_pc_q[i]    <= '0;
            ent_seq_q[i]   <= '0;
            ent_rs1_q[i]   <= '0;
            ent_rs2_q[i]   <= '0;
            ent_dep_q[i]   <= '0;
         end
         chk_valid_q    <= 1'b0;
         chk_seq_q      <= '0;
         chk_instr_q    <= '0;
         chk_pc_q       <= '0;
         chk_rs1_q      <= '0;
         chk_rs2_q      <= '0;
         chk_dep_q      <= '0;
         chk_rd_q       <= '0;
      end else begin
         state_q        <= state_d;
         launch_cnt_q   <= launch_cnt_d;
         count_q        <= count_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         age_q          <= age_d;
         err_timeout_q  <= err_timeout_d;
         err_spurious_q <= err_spurious_d;
         ent_instr_q    <= ent_instr_d;
         ent_pc_q       <= ent_pc_d;
         ent_seq_q      <= ent_seq_d;
         ent_rs1_q      <= ent_rs1_d;
         ent_rs2_q      <= ent_rs2_d;
         ent_dep_q      <= ent_dep_d;
         chk_valid_q    <= chk_valid_d;
         chk_seq_q      <= chk_seq_d;
         chk_instr_q    <= chk_instr_d;
         chk_pc_q       <= chk_pc_d;
         chk_rs1_q      <= chk_rs1_d;
         chk_rs2_q      <= chk_rs2_d;
         chk_dep_q      <= chk_dep_d;
         chk_rd_q       <= chk_rd_d;
      end
   end

   assign launched      = launch;
   assign nop_required  = !launch;
   assign slots_used    = count_q;
   assign state_o       = state_q;
   assign err_timeout   = err_timeout_q;
   assign err_spurious  = err_spurious_q;
   assign chk_valid     = chk_valid_q;
   assign chk_seq       = chk_seq_q;
   assign chk_instr     = chk_instr_q;
   assign chk_pc        = chk_pc_q;
   assign chk_rs1_value = chk_rs1_q;
   assign chk_rs2_value = chk_rs2_q;
   assign chk_rs_dep    = chk_dep_q;
   assign chk_rd_value  = chk_rd_q;

endmodule
`default_nettype wire
